// File: rtl/regfile_write_arbiter.sv
// Two-requester writeback arbiter for the register file write port.
// Each requester has a small FIFO; a round-robin arbiter drains them into a registered port.
module regfile_write_arbiter #(
  parameter int N     = 64,
  parameter int DEPTH = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [4:0]   req0_addr,
  input  logic [N-1:0] req0_data,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [4:0]   req1_addr,
  input  logic [N-1:0] req1_data,
  output logic         rf_write,
  output logic [4:0]   rf_DA,
  output logic [N-1:0] rf_D,
  output logic [31:0]  pend_mask,
  output logic         busy
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [4:0]    fifo_addr [2][DEPTH];
  logic [N-1:0]  fifo_data [2][DEPTH];
  logic [AW-1:0] wptr      [2];
  logic [AW-1:0] rptr      [2];
  logic [CW-1:0] count     [2];
  logic [4:0]    in_addr   [2];
  logic [N-1:0]  in_data   [2];
  logic [1:0]    in_valid, full, nonempty, push, pop;
  logic          gnt_valid, gnt_sel, last_grant;
  logic [4:0]    head_addr;
  logic [N-1:0]  head_data;
  logic [31:0]   mask;
  logic [AW-1:0] offset;

  assign in_valid   = {req1_valid, req0_valid};
  assign in_addr[0] = req0_addr;
  assign in_addr[1] = req1_addr;
  assign in_data[0] = req0_data;
  assign in_data[1] = req1_data;
  assign full       = {count[1] == CW'(DEPTH), count[0] == CW'(DEPTH)};
  assign nonempty   = {count[1] != '0, count[0] != '0};

  // valid/ready: a push happens on a posedge where valid & ready; ready depends only on
  // the pre-edge fill level, so a full FIFO refuses even if it pops on that same edge.
  assign req0_ready = reset & ~full[0];
  assign req1_ready = reset & ~full[1];
  assign push       = in_valid & {req1_ready, req0_ready};

  // Only entries present before the edge are eligible, so same-edge pushes never pop.
  always_comb begin
    gnt_valid = |nonempty;
    gnt_sel   = (&nonempty) ? ~last_grant : nonempty[1];
    pop       = 2'b00;
    if (gnt_valid) pop[gnt_sel] = 1'b1;
  end

  assign head_addr = fifo_addr[gnt_sel][rptr[gnt_sel]];
  assign head_data = fifo_data[gnt_sel][rptr[gnt_sel]];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 2; k++) begin
        wptr[k]  <= '0;
        rptr[k]  <= '0;
        count[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (push[k]) wptr[k] <= wptr[k] + AW'(1);
        if (pop[k])  rptr[k] <= rptr[k] + AW'(1);
        count[k] <= count[k] + CW'(push[k]) - CW'(pop[k]);
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int k = 0; k < 2; k++) begin
      if (push[k]) begin
        fifo_addr[k][wptr[k]] <= in_addr[k];
        fifo_data[k][wptr[k]] <= in_data[k];
      end
    end
  end

  // An entry is live when its distance from the read pointer is below the fill count.
  always_comb begin
    mask   = '0;
    offset = '0;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < DEPTH; i++) begin
        offset = AW'(i) - rptr[k];
        if (CW'(offset) < count[k]) mask[fifo_addr[k][i]] = 1'b1;
      end
    end
    if (rf_write) mask[rf_DA] = 1'b1;
    mask[31] = 1'b0;
  end

  assign pend_mask = mask;

  // X31 is hardwired zero: it drains normally but never raises the write enable.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rf_write   <= 1'b0;
      rf_DA      <= '0;
      rf_D       <= '0;
      last_grant <= 1'b1;
    end else if (gnt_valid) begin
      rf_write   <= (head_addr != 5'd31);
      rf_DA      <= head_addr;
      rf_D       <= head_data;
      last_grant <= gnt_sel;
    end else begin
      rf_write   <= 1'b0;
    end
  end

  assign busy = (|nonempty) | rf_write;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: queue-based reference model checked every cycle,
// a table of single writes on an idle port, and hand-written multi-cycle sequences.
module tb_regfile_write_arbiter;
  localparam int N     = 64;
  localparam int DEPTH = 2;

  logic         clock, reset;
  logic         v0, v1, req0_ready, req1_ready;
  logic [4:0]   a0, a1;
  logic [N-1:0] d0, d1;
  logic         rf_write, busy;
  logic [4:0]   rf_DA;
  logic [N-1:0] rf_D;
  logic [31:0]  pend_mask;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [4:0]   addr;
    logic [N-1:0] data;
  } ent_t;

  typedef struct {
    bit           req;
    logic [4:0]   addr;
    logic [N-1:0] data;
    logic [31:0]  exp_pend;
    bit           exp_write;
  } vec_t;

  regfile_write_arbiter #(.N(N), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(v0), .req0_ready(req0_ready), .req0_addr(a0), .req0_data(d0),
    .req1_valid(v1), .req1_ready(req1_ready), .req1_addr(a1), .req1_data(d1),
    .rf_write(rf_write), .rf_DA(rf_DA), .rf_D(rf_D),
    .pend_mask(pend_mask), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one queue per requester, a round-robin pointer and the output register.
  ent_t q0[$];
  ent_t q1[$];
  bit           m_last, m_write;
  logic [4:0]   m_da;
  logic [N-1:0] m_d;

  always @(posedge clock or negedge reset) begin : model
    ent_t h;
    bit   acc0, acc1, g;
    if (!reset) begin
      q0.delete();
      q1.delete();
      m_last  = 1'b1;
      m_write = 1'b0;
      m_da    = '0;
      m_d     = '0;
    end else begin
      acc0 = v0 && (q0.size() < DEPTH);
      acc1 = v1 && (q1.size() < DEPTH);
      if (q0.size() > 0 && q1.size() > 0) g = !m_last;
      else g = (q1.size() > 0);
      if (q0.size() > 0 || q1.size() > 0) begin
        if (g) h = q1.pop_front();
        else h = q0.pop_front();
        m_last  = g;
        m_write = (h.addr != 5'd31);
        m_da    = h.addr;
        m_d     = h.data;
      end else begin
        m_write = 1'b0;
      end
      if (acc0) q0.push_back('{a0, d0});
      if (acc1) q1.push_back('{a1, d1});
    end
  end

  function automatic logic [31:0] model_pend();
    logic [31:0] m = '0;
    foreach (q0[i]) m[q0[i].addr] = 1'b1;
    foreach (q1[i]) m[q1[i].addr] = 1'b1;
    if (m_write) m[m_da] = 1'b1;
    m[31] = 1'b0;
    return m;
  endfunction

  always @(negedge clock) begin
    if (reset) begin
      check("rf_write", rf_write, m_write);
      check("rf_DA", rf_DA, m_da);
      check("rf_D", rf_D, m_d);
      check("req0_ready", req0_ready, q0.size() < DEPTH);
      check("req1_ready", req1_ready, q1.size() < DEPTH);
      check("pend_mask", pend_mask, model_pend());
      check("busy", busy, (q0.size() > 0) || (q1.size() > 0) || m_write);
    end
  end

  // Both requesters stream n writes each, holding valid until accepted.
  task automatic stream(input int n);
    int i0 = 0, i1 = 0, acc1 = 0, stall_acc1 = -1, first = -1, last = -1;
    bit g0 = 0, g1 = 0;
    bit tags[$];
    for (int c = 0; c < 30; c++) begin
      @(negedge clock);
      if (rf_write) begin
        tags.push_back(rf_D[63]);
        if (first < 0) first = c;
        last = c;
      end
      if (v0 && g0) begin v0 = 1'b0; i0++; end
      if (v1 && g1) begin v1 = 1'b0; i1++; acc1++; end
      if (!v0 && i0 < n) begin v0 = 1'b1; a0 = 5'(1 + 2 * i0); d0 = {32'h0, 32'(i0)}; end
      if (!v1 && i1 < n) begin v1 = 1'b1; a1 = 5'(2 + 2 * i1); d1 = {32'h8000_0000, 32'(i1)}; end
      if (stall_acc1 < 0 && !req1_ready) stall_acc1 = acc1;
      g0 = req0_ready;
      g1 = req1_ready;
    end
    check("stream_writes", 64'(tags.size()), 64'(2 * n));
    check("stream_back_to_back", 64'(last - first + 1), 64'(2 * n));
    check("req1_stall_after", 64'(stall_acc1), 64'(DEPTH));
    foreach (tags[j]) check("alternate", 64'(tags[j]), 64'(j % 2));
  endtask

  vec_t tbl[6];

  initial begin
    bit g0 = 0, g1 = 0;
    tbl[0] = '{1'b0, 5'd5,  64'hDEAD,                  32'h0000_0020, 1'b1};
    tbl[1] = '{1'b1, 5'd17, 64'h1234_5678_9ABC_DEF0,   32'h0002_0000, 1'b1};
    tbl[2] = '{1'b0, 5'd31, 64'hFFFF,                  32'h0000_0000, 1'b0};
    tbl[3] = '{1'b1, 5'd0,  64'hFFFF_FFFF_FFFF_FFFF,   32'h0000_0001, 1'b1};
    tbl[4] = '{1'b1, 5'd31, 64'h5555,                  32'h0000_0000, 1'b0};
    tbl[5] = '{1'b0, 5'd30, 64'hA5A5_0000_0000_5A5A,   32'h4000_0000, 1'b1};

    reset = 1'b0; v0 = 1'b0; v1 = 1'b0; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
    repeat (2) @(negedge clock);
    check("reset_rf_write", rf_write, 1'b0);
    check("reset_rf_DA", rf_DA, 5'd0);
    check("reset_rf_D", rf_D, 64'd0);
    check("reset_ready", {req1_ready, req0_ready}, 2'b00);
    check("reset_pend", pend_mask, 32'd0);
    check("reset_busy", busy, 1'b0);
    reset = 1'b1;

    // Contested streams right after reset: req0 wins first, then strict alternation.
    stream(6);

    // Single writes on an idle port.
    foreach (tbl[t]) begin
      @(negedge clock);
      if (tbl[t].req) begin v1 = 1'b1; a1 = tbl[t].addr; d1 = tbl[t].data; end
      else begin v0 = 1'b1; a0 = tbl[t].addr; d0 = tbl[t].data; end
      @(posedge clock); #1;
      check("tbl_pend_queued", pend_mask, tbl[t].exp_pend);
      check("tbl_busy_queued", busy, 1'b1);
      @(negedge clock);
      v0 = 1'b0; v1 = 1'b0;
      @(posedge clock); #1;
      check("tbl_write", rf_write, tbl[t].exp_write);
      check("tbl_DA", rf_DA, tbl[t].addr);
      check("tbl_D", rf_D, tbl[t].data);
      check("tbl_pend_flight", pend_mask, tbl[t].exp_pend);
      check("tbl_busy_flight", busy, tbl[t].exp_write);
      @(posedge clock); #1;
      check("tbl_idle_write", rf_write, 1'b0);
      check("tbl_idle_pend", pend_mask, 32'd0);
      check("tbl_idle_busy", busy, 1'b0);
    end

    // Push and pop on the same edge with one entry queued.
    @(negedge clock);
    v0 = 1'b1; a0 = 5'd3; d0 = 64'hA;
    @(negedge clock);
    a0 = 5'd4; d0 = 64'hB;
    @(posedge clock); #1;
    check("pp_older_DA", rf_DA, 5'd3);
    check("pp_older_D", rf_D, 64'hA);
    check("pp_pend", pend_mask, 32'h0000_0018);
    check("pp_ready", req0_ready, 1'b1);
    @(negedge clock);
    v0 = 1'b0;
    @(posedge clock); #1;
    check("pp_next_D", rf_D, 64'hB);
    repeat (3) @(negedge clock);

    // Reset with both FIFOs holding data and a write in flight.
    v0 = 1'b1; a0 = 5'd9;  d0 = 64'h90;
    v1 = 1'b1; a1 = 5'd10; d1 = 64'hA0;
    @(negedge clock);
    a0 = 5'd11; d0 = 64'hB0;
    a1 = 5'd12; d1 = 64'hC0;
    @(posedge clock); #1;
    check("pre_reset_busy", busy, 1'b1);
    check("pre_reset_write", rf_write, 1'b1);
    #1 reset = 1'b0;
    #1;
    check("async_rf_write", rf_write, 1'b0);
    check("async_pend", pend_mask, 32'd0);
    check("async_ready", {req1_ready, req0_ready}, 2'b00);
    check("async_busy", busy, 1'b0);
    v0 = 1'b0; v1 = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    v0 = 1'b1; a0 = 5'd7; d0 = 64'h70;
    v1 = 1'b1; a1 = 5'd8; d1 = 64'h80;
    @(negedge clock);
    v0 = 1'b0; v1 = 1'b0;
    @(posedge clock); #1;
    check("post_reset_first_DA", rf_DA, 5'd7);
    check("post_reset_first_D", rf_D, 64'h70);
    repeat (4) @(negedge clock);

    // Random traffic, valid held until accepted.
    for (int c = 0; c < 400; c++) begin
      @(negedge clock);
      if (v0 && g0) v0 = 1'b0;
      if (v1 && g1) v1 = 1'b0;
      if (!v0 && $urandom_range(0, 2) != 0) begin
        v0 = 1'b1;
        a0 = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
        d0 = {$urandom, $urandom};
      end
      if (!v1 && $urandom_range(0, 2) != 0) begin
        v1 = 1'b1;
        a1 = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
        d1 = {$urandom, $urandom};
      end
      g0 = req0_ready;
      g1 = req1_ready;
    end
    @(negedge clock);
    if (v0 && g0) v0 = 1'b0;
    if (v1 && g1) v1 = 1'b0;
    begin
      int waited = 0;
      while ((v0 || v1 || busy) && waited < 40) begin
        g0 = req0_ready;
        g1 = req1_ready;
        @(negedge clock);
        if (v0 && g0) v0 = 1'b0;
        if (v1 && g1) v1 = 1'b0;
        waited++;
      end
      check("drain_timeout", 64'(waited < 40), 64'd1);
    end
    @(negedge clock);
    check("drain_busy", busy, 1'b0);
    check("drain_model_empty", 64'(q0.size() + q1.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
